// File: rtl/imem_pkg.sv
// Shared types for the instruction-fetch path: address/instruction widths,
// the queue entry layout and the fetch FSM state encoding.
package imem_pkg;

    localparam int ADDR_W     = 22;
    localparam int INSTR_W    = 22;
    localparam int WORD_BYTES = 4;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    typedef struct packed {
        instr_t instr;
        addr_t  pc;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic addr_t align_word(input addr_t a);
        return a & ~addr_t'(WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small in-order instruction queue. Entry 0 is always the head, so the
// head outputs come straight from flops; pops shift the entries down.
module fetch_queue
    import imem_pkg::*;
#(
    parameter  int QDEPTH = 2,
    localparam int CNT_W  = $clog2(QDEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     din,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     entries_q [QDEPTH];
    fetch_entry_t     entries_d [QDEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] level;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        do_pop    = pop && (count_q != '0);
        level     = count_q - CNT_W'(do_pop);
        do_push   = push && (level < CNT_W'(QDEPTH));
        // Flush wins over a simultaneous push: the incoming word belongs to a dead stream.
        if (flush) begin
            count_d = '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < QDEPTH - 1; i++) begin
                    entries_d[i] = entries_q[i+1];
                end
            end
            for (int i = 0; i < QDEPTH; i++) begin
                if (do_push && (level == CNT_W'(i))) begin
                    entries_d[i] = din;
                end
            end
            count_d = level + CNT_W'(do_push);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    assign head  = entries_q[0];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(QDEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: issues word fetches under a queue credit, tags each
// in-flight request with an epoch so redirects can discard stale returns.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter addr_t RESET_PC = '0,
    parameter int    QDEPTH   = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    output logic   imem_req,
    output addr_t  imem_addr,
    input  logic   imem_gnt,
    input  instr_t imem_rdata,
    input  logic   redirect_valid,
    input  addr_t  redirect_pc,
    input  logic   halt,
    output logic   instr_valid,
    output instr_t instr,
    output addr_t  instr_pc,
    input  logic   instr_ready
);

    localparam int CNT_W = $clog2(QDEPTH + 1);

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    addr_t            fetch_pc;
    logic             fire;
    logic             pop;
    logic [CNT_W:0]   occupancy;

    logic             vld_p1;
    logic             epoch_p1;
    addr_t            pc_p1;
    logic             epoch;

    logic             resp_push;
    fetch_entry_t     q_din;
    fetch_entry_t     q_head;
    logic [CNT_W-1:0] q_count;
    logic             q_full;
    logic             q_empty;

    assign fire = imem_req & imem_gnt;
    assign pop  = instr_valid & instr_ready;

    // A same-cycle pop frees a slot, which keeps one fetch per cycle in steady state.
    assign occupancy = {1'b0, q_count} - (CNT_W+1)'(pop) + (CNT_W+1)'(vld_p1);

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            RUN: begin
                if (halt) begin
                    state_d = HALT;
                end else begin
                    imem_req = rst_n && (occupancy < (CNT_W+1)'(QDEPTH));
                end
            end
            HALT: begin
                if (!halt) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // request stage: PC, FSM state and epoch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            fetch_pc <= RESET_PC;
            epoch    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (redirect_valid) begin
                fetch_pc <= align_word(redirect_pc);
                epoch    <= ~epoch;
            end else if (fire) begin
                fetch_pc <= fetch_pc + addr_t'(WORD_BYTES);
            end
        end
    end

    // response stage (p1): remembers which PC and epoch the returning word belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            epoch_p1 <= 1'b0;
            pc_p1    <= '0;
        end else begin
            vld_p1   <= fire;
            epoch_p1 <= epoch;
            if (fire) begin
                pc_p1 <= fetch_pc;
            end
        end
    end

    assign resp_push = vld_p1 && (epoch_p1 == epoch) && !q_full;
    assign q_din     = '{instr: imem_rdata, pc: pc_p1};

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (resp_push),
        .din   (q_din),
        .pop   (pop),
        .flush (redirect_valid),
        .head  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign imem_addr   = fetch_pc;
    assign instr_valid = !q_empty;
    assign instr       = q_head.instr;
    assign instr_pc    = q_head.pc;

endmodule
